user_rq_arbiter: RTL and testbench
==================================

# user_rq_arbiter

Packet-granular two-way arbiter that shares the PCIe AXI-S Requester Request (RQ) interface between requester 0, the configurator TLP path, and requester 1, the user I/O submission-queue path. It sits between those two sources and the core's `s_axis_rq_*` port. Grants alternate round-robin and are held until the granted packet's `tlast` beat is accepted, so TLPs are never interleaved. A pause input lets the user controller quiesce the link at a packet boundary.

## Interface
- `C_DATA_WIDTH`, 128, RQ data width.
- `KEEP_WIDTH`, `C_DATA_WIDTH/32`, tkeep width.
- `AXI4_RQ_TUSER_WIDTH`, 62, RQ tuser width.
- `user_clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s0_axis_rq_tdata/tkeep/tuser/tlast/tvalid`  in  C_DATA_WIDTH/KEEP_WIDTH/AXI4_RQ_TUSER_WIDTH/1/1  requester 0 stream.
- `s0_axis_rq_tready`  out  1  requester 0 ready.
- `s1_axis_rq_tdata/tkeep/tuser/tlast/tvalid`  in  same widths  requester 1 stream.
- `s1_axis_rq_tready`  out  1  requester 1 ready.
- `m_axis_rq_tdata/tkeep/tuser/tlast/tvalid`  out  same widths  to core RQ.
- `m_axis_rq_tready`  in  1  core ready.
- `arb_pause`  in  1  block new grants; the packet in flight completes.
- `arb_grant`  out  2  one-hot current selection (bit0 = req0); 0 when idle.
- `arb_busy`  out  1  high while a multi-beat packet is locked.
- `pkt_cnt0`, `pkt_cnt1`  out  16  packets completed per requester (see Configuration).

## Operation
- State registers:
  - `locked`: reset 0.
  - `lock_sel`: reset 0.
  - `last_sel`: reset 1, so requester 0 wins the first tie.
  - counters: reset 0.
- Arbitration:
  - When unlocked and `arb_pause`=0: `arb_sel` = the requester with `tvalid`.
  - If both are valid, `arb_sel` = `~last_sel`.
  - If neither is valid, nothing is selected.
- Effective selection: `sel` = `lock_sel` when locked; otherwise `arb_sel`.
- Datapath is combinational, zero latency:
  - `m_axis_rq_*` = the selected requester's data, keep, user, last and valid.
  - Selected `sX_tready` = `m_axis_rq_tready`; the non-selected `tready` = 0.
  - With no selection: `m_tvalid`=0, both `tready`=0, data outputs 0.
- Beat accepted = `m_tvalid & m_tready`:
  - Accept, `tlast`=0: `locked`<=1, `lock_sel`<=`sel`.
  - Accept, `tlast`=1: `locked`<=0, `last_sel`<=`sel`, and the counter for `sel` increments.
  - A single-beat packet never sets `locked`.
- States:
  - IDLE (`!locked`): arbitrating. Moves to LOCK on a non-last accept. Stays in IDLE on a last accept, with the pointer updated.
  - LOCK: stays until the last beat is accepted, then returns to IDLE.
- Holding rules:
  - While locked, the other requester's `tvalid` is ignored.
  - While locked, `arb_pause` is ignored.
  - `tvalid` dropping mid-packet leaves the lock held.
- `arb_pause`=1 in IDLE: no selection, so `m_tvalid`=0. Pending requests wait and their pointer is unchanged.
- `arb_grant` = one-hot `sel`. `arb_busy` = `locked`.
- Reset asserted mid-packet: immediately unlocks and the pointer returns to 1. The upstream source must also be reset; the truncated packet is not recovered.

## Timing
- Grant-to-data latency: 0 cycles. A request valid in cycle N can be accepted in cycle N.
- Back-to-back packets from alternating requesters incur no bubble cycles.
- Combinational paths:
  - `sX_tvalid` -> `m_tvalid`.
  - `m_tready` -> `sX_tready`.
  - No path from any `tready` to any `tvalid`.
- `pkt_cntX` updates the cycle after the last-beat accept. It wraps 0xFFFF -> 0x0000.

## Configuration
- `USER_RQ_ARB_PKTCNT_EN` defined: `pkt_cnt0`/`pkt_cnt1` are live 16-bit wrapping counters.
- `USER_RQ_ARB_PKTCNT_EN` undefined: the counters are not built and `pkt_cnt0`/`pkt_cnt1` are tied to 16'h0000.
- Arbitration behaviour is identical either way.

## Test plan
- Single source, no contention: req0 sends 3 beats (tlast on beat 3), `m_tready`=1 -> beats appear on `m_axis_rq_*` in cycles 0..2, `arb_busy`=1 after beat 1 and 0 after beat 3, `pkt_cnt0`=1.
- Contention: both requesters hold 2-beat packets from reset with `m_tready`=1 -> order is req0, req1, req0, req1 with no idle cycles, and `arb_grant` sequence is 01,01,10,10,01,….
- Backpressure and lock: req1 is granted and `m_tready`=0 for 4 cycles mid-packet while req0 is valid -> `s1_tready`=0 and `s0_tready`=0 throughout, the grant stays on req1, and req0 is served only after req1's tlast accept.
- Pause:
  - `arb_pause`=1 asserted during a req0 4-beat packet -> the packet completes.
  - Then `m_tvalid`=0 while req1 waits.
  - Deassert pause -> req1 is granted in the same cycle.
- Reset mid-packet: assert `reset` after beat 2 of 4 -> `arb_busy`=0, `arb_grant`=0, and the counters are 0 immediately. After release, a request valid from both requesters grants req0 first.
- Counter wrap (with `USER_RQ_ARB_PKTCNT_EN`): 65 536 single-beat req1 packets -> `pkt_cnt1` returns to 0. Without the macro, `pkt_cnt1` stays 0 throughout.

Source files
------------

// File: rtl/user_rq_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe RQ AXI-S port between two requesters.
// Optional per-requester packet counters are built when USER_RQ_ARB_PKTCNT_EN is defined.
module user_rq_arbiter #(
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RQ_TUSER_WIDTH = 62
) (
  input  logic                           user_clk,
  input  logic                           reset,
  input  logic [C_DATA_WIDTH-1:0]        s0_axis_rq_tdata,
  input  logic [KEEP_WIDTH-1:0]          s0_axis_rq_tkeep,
  input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s0_axis_rq_tuser,
  input  logic                           s0_axis_rq_tlast,
  input  logic                           s0_axis_rq_tvalid,
  output logic                           s0_axis_rq_tready,
  input  logic [C_DATA_WIDTH-1:0]        s1_axis_rq_tdata,
  input  logic [KEEP_WIDTH-1:0]          s1_axis_rq_tkeep,
  input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s1_axis_rq_tuser,
  input  logic                           s1_axis_rq_tlast,
  input  logic                           s1_axis_rq_tvalid,
  output logic                           s1_axis_rq_tready,
  output logic [C_DATA_WIDTH-1:0]        m_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_rq_tkeep,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] m_axis_rq_tuser,
  output logic                           m_axis_rq_tlast,
  output logic                           m_axis_rq_tvalid,
  input  logic                           m_axis_rq_tready,
  input  logic                           arb_pause,
  output logic [1:0]                     arb_grant,
  output logic                           arb_busy,
  output logic [15:0]                    pkt_cnt0,
  output logic [15:0]                    pkt_cnt1
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e state_q, state_d;
  logic   lock_sel_q, lock_sel_d;
  logic   last_sel_q, last_sel_d;
  logic   arb_vld, arb_sel;
  logic   sel_vld, sel;
  logic   accept;

  // New grants only at a packet boundary; reset also blocks selection so nothing is accepted.
  always_comb begin
    arb_vld = 1'b0;
    arb_sel = 1'b0;
    if (!reset && !arb_pause) begin
      if (s0_axis_rq_tvalid && s1_axis_rq_tvalid) begin
        arb_vld = 1'b1;
        arb_sel = ~last_sel_q;
      end else if (s0_axis_rq_tvalid) begin
        arb_vld = 1'b1;
        arb_sel = 1'b0;
      end else if (s1_axis_rq_tvalid) begin
        arb_vld = 1'b1;
        arb_sel = 1'b1;
      end
    end
  end

  assign sel_vld = (state_q == LOCK) || arb_vld;
  assign sel     = (state_q == LOCK) ? lock_sel_q : arb_sel;

  always_comb begin
    m_axis_rq_tdata   = '0;
    m_axis_rq_tkeep   = '0;
    m_axis_rq_tuser   = '0;
    m_axis_rq_tlast   = 1'b0;
    m_axis_rq_tvalid  = 1'b0;
    s0_axis_rq_tready = 1'b0;
    s1_axis_rq_tready = 1'b0;
    if (sel_vld && !sel) begin
      m_axis_rq_tdata   = s0_axis_rq_tdata;
      m_axis_rq_tkeep   = s0_axis_rq_tkeep;
      m_axis_rq_tuser   = s0_axis_rq_tuser;
      m_axis_rq_tlast   = s0_axis_rq_tlast;
      m_axis_rq_tvalid  = s0_axis_rq_tvalid;
      s0_axis_rq_tready = m_axis_rq_tready;
    end else if (sel_vld && sel) begin
      m_axis_rq_tdata   = s1_axis_rq_tdata;
      m_axis_rq_tkeep   = s1_axis_rq_tkeep;
      m_axis_rq_tuser   = s1_axis_rq_tuser;
      m_axis_rq_tlast   = s1_axis_rq_tlast;
      m_axis_rq_tvalid  = s1_axis_rq_tvalid;
      s1_axis_rq_tready = m_axis_rq_tready;
    end
  end

  assign accept    = m_axis_rq_tvalid && m_axis_rq_tready;
  assign arb_grant = sel_vld ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign arb_busy  = (state_q == LOCK);

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    last_sel_d = last_sel_q;
    if (accept) begin
      if (m_axis_rq_tlast) begin
        state_d    = IDLE;
        last_sel_d = sel;
      end else begin
        state_d    = LOCK;
        lock_sel_d = sel;
      end
    end
  end

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_sel_q <= 1'b0;
      last_sel_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      last_sel_q <= last_sel_d;
    end
  end

`ifdef USER_RQ_ARB_PKTCNT_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && m_axis_rq_tlast) begin
      if (sel) cnt1_d = cnt1_q + 16'd1;
      else     cnt0_d = cnt0_q + 16'd1;
    end
  end

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = 16'h0000;
  assign pkt_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_user_rq_arbiter.sv
// Scoreboard bench for user_rq_arbiter: queued source packets, expected beat order, direct status checks.
module tb_user_rq_arbiter;

  localparam int DW = 128;
  localparam int KW = 4;
  localparam int UW = 62;
`ifdef USER_RQ_ARB_PKTCNT_EN
  localparam bit CNT_EN = 1'b1;
  localparam int WRAP_N = 65536;
`else
  localparam bit CNT_EN = 1'b0;
  localparam int WRAP_N = 32;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic          src;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
  logic          s0_tlast, s1_tlast, m_tlast;
  logic          s0_tvalid, s1_tvalid, m_tvalid;
  logic          s0_tready, s1_tready;
  logic          m_ready = 1'b1;
  logic          arb_pause = 1'b0;
  logic [1:0]    arb_grant;
  logic          arb_busy;
  logic [15:0]   pkt_cnt0, pkt_cnt1;

  beat_t src0[$], src1[$], pend0[$], pend1[$], exp_q[$];
  logic [15:0] cnt_exp0 = 16'd0;
  logic [15:0] cnt_exp1 = 16'd0;
  int          pkt_id = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  user_rq_arbiter dut (
    .user_clk(clk), .reset(reset),
    .s0_axis_rq_tdata(s0_tdata), .s0_axis_rq_tkeep(s0_tkeep), .s0_axis_rq_tuser(s0_tuser),
    .s0_axis_rq_tlast(s0_tlast), .s0_axis_rq_tvalid(s0_tvalid), .s0_axis_rq_tready(s0_tready),
    .s1_axis_rq_tdata(s1_tdata), .s1_axis_rq_tkeep(s1_tkeep), .s1_axis_rq_tuser(s1_tuser),
    .s1_axis_rq_tlast(s1_tlast), .s1_axis_rq_tvalid(s1_tvalid), .s1_axis_rq_tready(s1_tready),
    .m_axis_rq_tdata(m_tdata), .m_axis_rq_tkeep(m_tkeep), .m_axis_rq_tuser(m_tuser),
    .m_axis_rq_tlast(m_tlast), .m_axis_rq_tvalid(m_tvalid), .m_axis_rq_tready(m_ready),
    .arb_pause(arb_pause), .arb_grant(arb_grant), .arb_busy(arb_busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    if (src0.size() > 0) begin
      s0_tvalid = 1'b1; s0_tdata = src0[0].data; s0_tkeep = src0[0].keep;
      s0_tuser = src0[0].user; s0_tlast = src0[0].last;
    end else begin
      s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tuser = '0; s0_tlast = 1'b0;
    end
    if (src1.size() > 0) begin
      s1_tvalid = 1'b1; s1_tdata = src1[0].data; s1_tkeep = src1[0].keep;
      s1_tuser = src1[0].user; s1_tlast = src1[0].last;
    end else begin
      s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tuser = '0; s1_tlast = 1'b0;
    end
  endtask

  task automatic push_pkt(input bit src, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom(), $urandom(), $urandom(), 7'd0, src, pkt_id[15:0], i[7:0]};
      b.keep = b.data[KW+39:40];
      b.user = {b.data[93:64], b.data[31:0]};
      b.last = (i == nbeats - 1);
      b.src  = src;
      if (src) begin src1.push_back(b); pend1.push_back(b); end
      else     begin src0.push_back(b); pend0.push_back(b); end
    end
    pkt_id++;
    drive();
  endtask

  // Moves the oldest pending packet of a source into the expected output order.
  task automatic expect_pkt(input bit src);
    beat_t b;
    do begin
      b = src ? pend1.pop_front() : pend0.pop_front();
      exp_q.push_back(b);
    end while (!b.last);
  endtask

  task automatic tick();
    bit a0, a1;
    beat_t e;
    @(negedge clk);
    a0 = s0_tvalid && s0_tready;
    a1 = s1_tvalid && s1_tready;
    if (m_tvalid && m_ready) begin
      check_eq("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("m_tdata", m_tdata, e.data);
        check_eq("m_tkeep", m_tkeep, e.keep);
        check_eq("m_tuser", m_tuser, e.user);
        check_eq("m_tlast", m_tlast, e.last);
        if (e.last) begin
          if (e.src) cnt_exp1 = cnt_exp1 + 16'd1;
          else       cnt_exp0 = cnt_exp0 + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (a0) void'(src0.pop_front());
    if (a1) void'(src1.pop_front());
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_done", exp_q.size(), 0);
  endtask

  task automatic flush();
    src0.delete(); src1.delete(); pend0.delete(); pend1.delete(); exp_q.delete();
    cnt_exp0 = 16'd0;
    cnt_exp1 = 16'd0;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
    check_eq({tag, "_cnt0"}, pkt_cnt0, CNT_EN ? cnt_exp0 : 16'd0);
    check_eq({tag, "_cnt1"}, pkt_cnt1, CNT_EN ? cnt_exp1 : 16'd0);
  endtask

  initial begin
    logic [1:0] gseq [8];
    gseq = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};

    // Reset state
    do_reset();
    #1;
    check_eq("rst_grant", arb_grant, 2'b00);
    check_eq("rst_busy", arb_busy, 0);
    check_eq("rst_mvalid", m_tvalid, 0);
    check_eq("rst_tready", {s0_tready, s1_tready}, 2'b00);
    check_cnts("rst");

    // Single source, 3-beat packet
    push_pkt(0, 3); expect_pkt(0);
    #1;
    check_eq("single_grant", arb_grant, 2'b01);
    check_eq("single_mvalid", m_tvalid, 1);
    check_eq("single_busy0", arb_busy, 0);
    tick(); #1; check_eq("single_busy1", arb_busy, 1);
    tick(); #1; check_eq("single_busy2", arb_busy, 1);
    tick(); #1; check_eq("single_busy3", arb_busy, 0);
    check_eq("single_done", exp_q.size(), 0);
    check_cnts("single");

    // Contention from reset: alternate req0, req1 with no bubbles
    do_reset();
    push_pkt(0, 2); push_pkt(0, 2); push_pkt(1, 2); push_pkt(1, 2);
    expect_pkt(0); expect_pkt(1); expect_pkt(0); expect_pkt(1);
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("cont_grant%0d", i), arb_grant, gseq[i]);
      check_eq($sformatf("cont_mvalid%0d", i), m_tvalid, 1);
      tick();
    end
    drain(10);
    check_cnts("cont");

    // Backpressure while req1 holds the lock and req0 waits
    push_pkt(1, 3); expect_pkt(1);
    #1; check_eq("bp_grant_start", arb_grant, 2'b10);
    tick();
    push_pkt(0, 1); expect_pkt(0);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("bp_tready%0d", i), {s0_tready, s1_tready}, 2'b00);
      check_eq($sformatf("bp_grant%0d", i), arb_grant, 2'b10);
      check_eq($sformatf("bp_busy%0d", i), arb_busy, 1);
      tick();
    end
    m_ready = 1'b1;
    drain(10);
    check_cnts("bp");

    // Pause during a req0 packet: packet completes, then link idles until release
    push_pkt(0, 4); expect_pkt(0);
    #1; check_eq("pause_grant_start", arb_grant, 2'b01);
    tick();
    arb_pause = 1'b1;
    push_pkt(1, 2); expect_pkt(1);
    #1; check_eq("pause_held_grant", arb_grant, 2'b01);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq($sformatf("pause_mvalid%0d", i), m_tvalid, 0);
      check_eq($sformatf("pause_grant%0d", i), arb_grant, 2'b00);
      check_eq($sformatf("pause_s1_tready%0d", i), s1_tready, 0);
      check_eq($sformatf("pause_mdata%0d", i), m_tdata, 0);
      tick();
    end
    arb_pause = 1'b0;
    #1;
    check_eq("unpause_grant", arb_grant, 2'b10);
    check_eq("unpause_mvalid", m_tvalid, 1);
    drain(10);
    check_cnts("pause");

    // Reset mid-packet after req0 was last served: pointer must return to favour req0
    push_pkt(0, 1); expect_pkt(0);
    drain(5);
    push_pkt(0, 4); expect_pkt(0);
    tick(); tick();
    #1; check_eq("midrst_busy_pre", arb_busy, 1);
    reset = 1'b1;
    flush();
    #1;
    check_eq("midrst_busy", arb_busy, 0);
    check_eq("midrst_grant", arb_grant, 2'b00);
    check_eq("midrst_cnt0", pkt_cnt0, 16'd0);
    check_eq("midrst_cnt1", pkt_cnt1, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_pkt(1, 1); push_pkt(0, 1);
    expect_pkt(0); expect_pkt(1);
    #1; check_eq("midrst_first_grant", arb_grant, 2'b01);
    drain(5);
    check_cnts("midrst");

    // Counter wrap on req1 single-beat packets
    do_reset();
    for (int i = 0; i < WRAP_N; i++) begin
      push_pkt(1, 1);
      expect_pkt(1);
    end
    drain(WRAP_N + 10);
    check_cnts("wrap");
    check_eq("wrap_cnt1_zero", pkt_cnt1, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
